// File: rtl/filter_pump_ctrl_if.sv
// Pump controller bus: sequencing inputs toward the controller, PWM/status back.
interface filter_pump_ctrl_if #(
  parameter int unsigned N_SENSORS = 4,
  parameter int unsigned PWM_W     = 8
);
  logic                 enable;
  logic [N_SENSORS-1:0] status_data;
  logic                 is_empty;
  logic                 fault_clear;
  logic [PWM_W-1:0]     pwm_duty_a;
  logic [PWM_W-1:0]     pwm_duty_b;
  logic [2:0]           state_o;
  logic                 fault;

  // Supervisor side: drives sensors/commands, observes pump outputs
  modport master (
    output enable, status_data, is_empty, fault_clear,
    input  pwm_duty_a, pwm_duty_b, state_o, fault
  );

  // Controller side
  modport slave (
    input  enable, status_data, is_empty, fault_clear,
    output pwm_duty_a, pwm_duty_b, state_o, fault
  );
endinterface

// File: rtl/filter_pump_ctrl.sv
// Two-pump filter sequencer: fill with pump A, drain with pump B (min then max
// duty), slew-limited duties, drain-timeout fault and graceful stop on enable.
module filter_pump_ctrl #(
  parameter int unsigned          N_SENSORS            = 4,
  parameter logic [N_SENSORS-1:0] SENSOR_MASK          = '1,
  parameter int unsigned          PWM_W                = 8,
  parameter int unsigned          PWM_MIN              = 77,
  parameter int unsigned          PWM_MAX              = 230,
  parameter longint unsigned      FILL_CYCLES          = 64'd6_000_000_000,
  parameter longint unsigned      MIN_HOLD_CYCLES      = 64'd250_000_000,
  parameter longint unsigned      DRAIN_TIMEOUT_CYCLES = 64'd500_000_000,
  parameter int unsigned          RAMP_STEP            = 8,
  parameter int unsigned          RAMP_DIV             = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  filter_pump_ctrl_if.slave      bus
);

  localparam longint unsigned MAX_A   = (FILL_CYCLES > MIN_HOLD_CYCLES) ? FILL_CYCLES : MIN_HOLD_CYCLES;
  localparam longint unsigned MAX_CYC = (MAX_A > DRAIN_TIMEOUT_CYCLES) ? MAX_A : DRAIN_TIMEOUT_CYCLES;
  localparam int unsigned     TMR_W   = $clog2(MAX_CYC) + 1;
  localparam int unsigned     DIV_W   = $clog2(RAMP_DIV) + 1;
  localparam int unsigned     DW      = PWM_W + 1;

  localparam logic [TMR_W-1:0] FILL_LAST = TMR_W'(FILL_CYCLES - 64'd1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(MIN_HOLD_CYCLES - 64'd1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(DRAIN_TIMEOUT_CYCLES - 64'd1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(RAMP_DIV - 1);
  localparam logic [PWM_W-1:0] DUTY_MIN  = PWM_W'(PWM_MIN);
  localparam logic [PWM_W-1:0] DUTY_MAX  = PWM_W'(PWM_MAX);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILLING   = 3'd1,
    ST_DRAIN_MIN = 3'd2,
    ST_DRAIN_MAX = 3'd3,
    ST_STOPPING  = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PWM_W-1:0]   duty_a_q, duty_a_d;
  logic [PWM_W-1:0]   duty_b_q, duty_b_d;
  logic               fault_q, fault_d;
  logic               critical_c;
  logic               ramp_tick_c;
  logic [PWM_W-1:0]   tgt_a_c, tgt_b_c;

  // Move one ramp step from cur toward tgt, landing exactly on tgt
  function automatic logic [PWM_W-1:0] ramp(input logic [PWM_W-1:0] cur,
                                            input logic [PWM_W-1:0] tgt);
    logic [DW-1:0] cur_w, tgt_w, step_w, sum_w, gap_w;
    logic [PWM_W-1:0] res;
    cur_w  = {1'b0, cur};
    tgt_w  = {1'b0, tgt};
    step_w = DW'(RAMP_STEP);
    sum_w  = cur_w + step_w;
    gap_w  = cur_w - tgt_w;
    res    = cur;
    if (cur_w < tgt_w) begin
      res = (sum_w > tgt_w) ? tgt : sum_w[PWM_W-1:0];
    end else if (cur_w > tgt_w) begin
      res = (gap_w <= step_w) ? tgt : PWM_W'(cur_w - step_w);
    end
    return res;
  endfunction

  assign critical_c = |(bus.status_data & SENSOR_MASK);

  // Next state, state timer and fault flag
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fault_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable && critical_c) state_d = ST_FILLING;
      end
      ST_FILLING: begin
        if (!bus.enable)               state_d = ST_STOPPING;
        else if (timer_q == FILL_LAST) state_d = ST_DRAIN_MIN;
      end
      ST_DRAIN_MIN: begin
        if (!bus.enable || !critical_c) state_d = ST_STOPPING;
        else if (timer_q == HOLD_LAST)  state_d = ST_DRAIN_MAX;
        else if (bus.is_empty)          state_d = ST_FILLING;
      end
      ST_DRAIN_MAX: begin
        if (!bus.enable || !critical_c) state_d = ST_STOPPING;
        else if (bus.is_empty)          state_d = ST_FILLING;
      end
      ST_STOPPING: begin
        if (bus.is_empty)            state_d = ST_IDLE;
        else if (timer_q == TO_LAST) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (bus.fault_clear && !critical_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q)  timer_d = '0;
    else if (timer_q != '1)  timer_d = timer_q + TMR_W'(1);
    fault_d = (state_d == ST_FAULT);
  end

  // Free-running ramp divider
  always_comb begin
    ramp_tick_c = (div_q == DIV_LAST);
    div_d       = ramp_tick_c ? '0 : div_q + DIV_W'(1);
  end

  // Duty targets from registered state, then safety cut or slew-limited ramp
  always_comb begin
    tgt_a_c = '0;
    tgt_b_c = '0;
    unique case (state_q)
      ST_FILLING:   tgt_a_c = DUTY_MAX;
      ST_DRAIN_MIN: tgt_b_c = DUTY_MIN;
      ST_DRAIN_MAX: tgt_b_c = DUTY_MAX;
      ST_STOPPING:  tgt_b_c = DUTY_MIN;
      default: ;
    endcase
    duty_a_d = duty_a_q;
    duty_b_d = duty_b_q;
    if (tgt_a_c == '0 || state_q == ST_FAULT) duty_a_d = '0;
    else if (ramp_tick_c)                     duty_a_d = ramp(duty_a_q, tgt_a_c);
    if (tgt_b_c == '0 || state_q == ST_FAULT) duty_b_d = '0;
    else if (ramp_tick_c)                     duty_b_d = ramp(duty_b_q, tgt_b_c);
  end

  // State, timer, divider, duty and fault registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      div_q    <= '0;
      duty_a_q <= '0;
      duty_b_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      div_q    <= div_d;
      duty_a_q <= duty_a_d;
      duty_b_q <= duty_b_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.pwm_duty_a = duty_a_q;
  assign bus.pwm_duty_b = duty_b_q;
  assign bus.state_o    = state_q;
  assign bus.fault      = fault_q;

endmodule

// File: doc/filter_pump_ctrl.md
Name: filter_pump_ctrl

Overview:
Parametrised two-pump filter sequencer. It fills the filter with pump A and drains it with pump B, which runs at a minimum duty first and escalates to maximum duty. The sequence is triggered by a masked OR of N sensor flags and gated by an enable. This generation adds configurable timings and duty levels, slew-limited PWM ramping, a drain-timeout fault with latched clear, and an enable-driven graceful stop. Outputs feed the existing PWM generators directly.

Parameters:
N_SENSORS, 4, width of status_data
SENSOR_MASK, all ones (N_SENSORS bits), bit i=1 lets status_data[i] count as critical
PWM_W, 8, duty width
PWM_MIN, 77, pump B low duty
PWM_MAX, 230, pump A fill duty and pump B high duty
FILL_CYCLES, 6_000_000_000, cycles spent in FILLING (≥1)
MIN_HOLD_CYCLES, 250_000_000, cycles in DRAIN_MIN before escalation (≥1)
DRAIN_TIMEOUT_CYCLES, 500_000_000, max cycles in STOPPING before FAULT (≥1)
RAMP_STEP, 8, duty change per ramp tick (≥1)
RAMP_DIV, 1, cycles per ramp tick (≥1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  1 = sequencing allowed
status_data  in  N_SENSORS  sensor flags
is_empty  in  1  filter empty
fault_clear  in  1  level; releases FAULT
pwm_duty_a  out  PWM_W  pump A duty
pwm_duty_b  out  PWM_W  pump B duty
state_o  out  3  IDLE=0 FILLING=1 DRAIN_MIN=2 DRAIN_MAX=3 STOPPING=4 FAULT=5
fault  out  1  high while in FAULT

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`. On reset: state IDLE, all timers 0, ramp divider 0, both duties 0, fault 0.
- critical = |(status_data & SENSOR_MASK), combinational, not registered.
- A single state timer clears to 0 on every state change and otherwise increments each cycle (width $clog2 of the largest count +1, no wrap).
- Transitions are evaluated each cycle. Within a state, earlier conditions win.
  - IDLE: enable && critical -> FILLING.
  - FILLING: !enable -> STOPPING; timer==FILL_CYCLES-1 -> DRAIN_MIN. critical is ignored, so FILLING occupies exactly FILL_CYCLES cycles.
  - DRAIN_MIN: !enable or !critical -> STOPPING; timer==MIN_HOLD_CYCLES-1 -> DRAIN_MAX; is_empty -> FILLING.
  - DRAIN_MAX: !enable or !critical -> STOPPING; is_empty -> FILLING.
  - STOPPING: is_empty -> IDLE; timer==DRAIN_TIMEOUT_CYCLES-1 -> FAULT. If is_empty and the timeout occur in the same cycle, IDLE wins.
  - FAULT: fault_clear && !critical -> IDLE. Otherwise stay; enable has no effect.
  - Illegal encoding -> IDLE.
- Duty targets (A,B) per state: IDLE (0,0); FILLING (PWM_MAX,0); DRAIN_MIN (0,PWM_MIN); DRAIN_MAX (0,PWM_MAX); STOPPING (0,PWM_MIN); FAULT (0,0).
- Duties are registered. Targets derive from the registered state, so a duty first responds on the clock edge after the state changes.
- Ramping:
  - Target 0 or state FAULT: duty becomes 0 on the next edge, with no ramp. This is a safety rule.
  - Otherwise, on each ramp tick the duty moves toward the target by RAMP_STEP and saturates exactly at the target, with no overshoot. Compute in PWM_W+1 bits.
  - The ramp tick comes from a free-running divider that fires every RAMP_DIV cycles; with RAMP_DIV=1 it fires every cycle.
  - Ramping starts from the current duty value, including 0.
- fault = (state==FAULT), registered together with the state.
- Reset mid-operation returns everything to reset values on the next edge, and duties go to 0 immediately.

Test Plan:
All scenarios use FILL=8, MIN_HOLD=6, TIMEOUT=10, PWM_MIN=77, PWM_MAX=230, RAMP_STEP=50, RAMP_DIV=1, SENSOR_MASK=4'b1111, enable=1.
- Normal cycle: status_data=4'b0010 with is_empty=0 -> state_o 1 for exactly 8 cycles, then 2. pwm_a goes 50,100,150,200,230 then 0 on DRAIN_MIN. pwm_b goes 50,77. After 6 cycles state_o=3 and pwm_b goes 127,177,227,230.
- Clean stop: in DRAIN_MAX, drop status_data to 0 -> STOPPING, pwm_b ramps 230→180→130→80→77. Assert is_empty -> IDLE and both duties 0 next edge.
- Timeout fault: enter STOPPING and hold is_empty=0 -> after 10 cycles state_o=5, fault=1, duties 0. Asserting fault_clear with status_data≠0 keeps FAULT. Asserting fault_clear with status_data=0 -> IDLE, fault=0.
- Refill loop: in DRAIN_MIN with critical=1, assert is_empty at timer=3 -> FILLING, timer restarts, FILLING lasts 8 cycles. Repeat the same from DRAIN_MAX.
- Mask and enable: SENSOR_MASK=4'b1110 with status_data=4'b0001 -> stays IDLE. With enable=0 and status_data=4'b0100 -> stays IDLE. Deassert enable mid-FILLING -> STOPPING next edge and pwm_a=0.
- Reset mid-DRAIN_MAX with pwm_b=230 -> next edge state_o=0, both duties 0, fault 0. Also check the STOPPING tie (is_empty together with timeout) -> IDLE, not FAULT.
